// File: rtl/mouse_ps2_pkg.sv
// Shared types and PS/2 protocol constants for the mouse sequencing controller
// and its packet framer.
package mouse_ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_RST,
        ST_WAIT_ACK_RST,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_SEND_EN,
        ST_WAIT_ACK_EN,
        ST_STREAM,
        ST_FAIL
    } state_e;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID_STD = 8'h00;

    typedef struct packed {
        logic [8:0] dx;
        logic [8:0] dy;
        logic [2:0] btn;
    } pkt_t;

    // Sign bits live in byte 0; an overflow flag zeroes the matching axis.
    function automatic pkt_t assemble_pkt(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2);
        pkt_t p;
        p.dx  = b0[6] ? 9'd0 : {b0[4], b1};
        p.dy  = b0[7] ? 9'd0 : {b0[5], b2};
        p.btn = b0[2:0];
        return p;
    endfunction

endpackage

// File: rtl/mouse_ps2_pkt_framer.sv
// Frames 3-byte PS/2 movement packets while streaming and presents each one
// over a valid/ack handshake, flagging packets overwritten before ack.
module mouse_ps2_pkt_framer
    import mouse_ps2_pkg::*;
#(
    parameter int GAP_CYCLES = 100_000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_err,
    input  logic       pkt_ack,
    output pkt_t       pkt,
    output logic       pkt_valid,
    output logic       pkt_lost
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Handshake: pkt is stable while pkt_valid is high; the packet is consumed
    // in the cycle pkt_ack is sampled high with pkt_valid high.
    logic [1:0]    cnt_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    b0_q, b1_q;
    pkt_t          pkt_q;
    logic          valid_q, lost_q;
    logic          done, gap_expired;

    assign done        = rx_valid && !rx_err && (cnt_q == 2'd2);
    assign gap_expired = (cnt_q != 2'd0) && !rx_valid && (gap_q == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= 2'd0;
            gap_q   <= '0;
            b0_q    <= 8'h00;
            b1_q    <= 8'h00;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end else if (clr || !en) begin
            cnt_q   <= 2'd0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            if (clr) lost_q <= 1'b0;
        end else begin
            if (rx_valid || cnt_q == 2'd0) gap_q <= '0;
            else                           gap_q <= gap_q + GW'(1);

            if (rx_err || gap_expired) begin
                cnt_q <= 2'd0;
            end else if (rx_valid) begin
                case (cnt_q)
                    2'd0: if (rx_byte[3]) begin
                        b0_q  <= rx_byte;
                        cnt_q <= 2'd1;
                    end
                    2'd1: begin
                        b1_q  <= rx_byte;
                        cnt_q <= 2'd2;
                    end
                    default: cnt_q <= 2'd0;
                endcase
            end

            if (done) begin
                pkt_q   <= assemble_pkt(b0_q, b1_q, rx_byte);
                valid_q <= 1'b1;
                if (valid_q && !pkt_ack) lost_q <= 1'b1;
            end else if (pkt_ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign pkt       = pkt_q;
    assign pkt_valid = valid_q;
    assign pkt_lost  = lost_q;

endmodule

// File: rtl/mouse_ps2_ctrl.sv
// Sequencing controller: runs the PS/2 mouse init handshake with retries and
// hands streaming movement packets to the framer.
module mouse_ps2_ctrl
    import mouse_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int GAP_CYCLES     = 100_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    output logic [7:0] tx_byte_o,
    output logic       tx_req_o,
    input  logic       tx_done_i,
    input  logic       tx_err_i,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_valid_i,
    input  logic       rx_err_i,
    output logic       pkt_valid_o,
    input  logic       pkt_ack_i,
    output logic [8:0] dx_o,
    output logic [8:0] dy_o,
    output logic [2:0] btn_o,
    output logic       pkt_lost_o,
    output logic       init_done_o,
    output logic       init_fail_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRIES + 1);

    state_e        state_q, state_d;
    logic          enter, bad_byte, fail, init_st, timeout;
    logic          send_entry_q;
    logic [TW-1:0] timer_q;
    logic [RW-1:0] retry_q;
    logic [7:0]    tx_byte_q;
    pkt_t          pkt;

    assign init_st = state_q inside {ST_SEND_RST, ST_WAIT_ACK_RST, ST_WAIT_BAT,
                                     ST_WAIT_ID, ST_SEND_EN, ST_WAIT_ACK_EN};
    assign timeout = init_st && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        enter    = 1'b0;
        bad_byte = 1'b0;
        fail     = 1'b0;
        case (state_q)
            ST_SEND_RST: if (tx_done_i) begin
                state_d = ST_WAIT_ACK_RST; enter = 1'b1;
            end
            ST_WAIT_ACK_RST: if (rx_valid_i) begin
                if (rx_byte_i == RSP_ACK)         begin state_d = ST_WAIT_BAT; enter = 1'b1; end
                else if (rx_byte_i == RSP_RESEND) begin state_d = ST_SEND_RST; enter = 1'b1; end
                else                              bad_byte = 1'b1;
            end
            ST_WAIT_BAT: if (rx_valid_i) begin
                if (rx_byte_i == RSP_BAT_OK) begin state_d = ST_WAIT_ID; enter = 1'b1; end
                else                         bad_byte = 1'b1;
            end
            ST_WAIT_ID: if (rx_valid_i) begin
                if (rx_byte_i == RSP_ID_STD) begin state_d = ST_SEND_EN; enter = 1'b1; end
                else                         bad_byte = 1'b1;
            end
            ST_SEND_EN: if (tx_done_i) begin
                state_d = ST_WAIT_ACK_EN; enter = 1'b1;
            end
            ST_WAIT_ACK_EN: if (rx_valid_i) begin
                if (rx_byte_i == RSP_ACK)         begin state_d = ST_STREAM;  enter = 1'b1; end
                else if (rx_byte_i == RSP_RESEND) begin state_d = ST_SEND_EN; enter = 1'b1; end
                else                              bad_byte = 1'b1;
            end
            default: ;
        endcase

        fail = init_st && (bad_byte || rx_err_i || tx_err_i || timeout);
        if (fail) begin
            enter   = 1'b1;
            state_d = (int'(retry_q) + 1 < MAX_RETRIES) ? ST_SEND_RST : ST_FAIL;
        end
        // Restart wins over anything else happening in the same cycle.
        if (start_i) begin
            enter   = 1'b1;
            state_d = ST_SEND_RST;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            send_entry_q <= 1'b0;
            timer_q      <= '0;
            retry_q      <= '0;
            tx_byte_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            send_entry_q <= enter && (state_d == ST_SEND_RST || state_d == ST_SEND_EN);

            if (enter)        timer_q <= '0;
            else if (init_st) timer_q <= timer_q + TW'(1);

            if (start_i)   retry_q <= '0;
            else if (fail) retry_q <= retry_q + RW'(1);

            if (enter && state_d == ST_SEND_RST)     tx_byte_q <= CMD_RESET;
            else if (enter && state_d == ST_SEND_EN) tx_byte_q <= CMD_ENABLE;
        end
    end

    mouse_ps2_pkt_framer #(.GAP_CYCLES(GAP_CYCLES)) u_framer (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .en        (state_q == ST_STREAM),
        .clr       (start_i),
        .rx_byte   (rx_byte_i),
        .rx_valid  (rx_valid_i),
        .rx_err    (rx_err_i),
        .pkt_ack   (pkt_ack_i),
        .pkt       (pkt),
        .pkt_valid (pkt_valid_o),
        .pkt_lost  (pkt_lost_o)
    );

    assign tx_req_o    = send_entry_q;
    assign tx_byte_o   = tx_byte_q;
    assign dx_o        = pkt.dx;
    assign dy_o        = pkt.dy;
    assign btn_o       = pkt.btn;
    assign init_done_o = (state_q == ST_STREAM);
    assign init_fail_o = (state_q == ST_FAIL);

endmodule

// File: tb/tb_mouse_ps2_ctrl.sv
// Directed bench for mouse_ps2_ctrl: init handshake, retries, timeouts,
// packet framing and the valid/ack handshake.
module tb_mouse_ps2_ctrl;

    localparam int TMO = 100;
    localparam int GAP = 50;

    logic       clk_i = 1'b0;
    logic       rstn_i, start_i, tx_done_i, tx_err_i, rx_valid_i, rx_err_i, pkt_ack_i;
    logic [7:0] rx_byte_i, tx_byte_o;
    logic       tx_req_o, pkt_valid_o, pkt_lost_o, init_done_o, init_fail_o;
    logic [8:0] dx_o, dy_o;
    logic [2:0] btn_o;

    logic [20:0] exp_q[$];
    logic [7:0]  exp_tx[$];
    int n_assert = 0;
    int n_fail   = 0;

    mouse_ps2_ctrl #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .MAX_RETRIES(3)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .tx_byte_o(tx_byte_o), .tx_req_o(tx_req_o), .tx_done_i(tx_done_i), .tx_err_i(tx_err_i),
        .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i), .rx_err_i(rx_err_i),
        .pkt_valid_o(pkt_valid_o), .pkt_ack_i(pkt_ack_i),
        .dx_o(dx_o), .dy_o(dy_o), .btn_o(btn_o), .pkt_lost_o(pkt_lost_o),
        .init_done_o(init_done_o), .init_fail_o(init_fail_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        exp_tx.push_back(8'hFF);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_tx();
        repeat (6) tick();
    endtask

    task automatic ack_pkt();
        pkt_ack_i = 1'b1;
        tick();
        pkt_ack_i = 1'b0;
    endtask

    task automatic check_pkt(input string tag);
        logic [20:0] e;
        e = exp_q.pop_front();
        check(tag, {11'd0, dx_o, dy_o, btn_o}, {11'd0, e});
    endtask

    task automatic finish_init();
        send_rx(8'hFA);
        send_rx(8'hAA);
        exp_tx.push_back(8'hF4);
        send_rx(8'h00);
        wait_tx();
        send_rx(8'hFA);
    endtask

    // transmitter model: tx_done two cycles after each request
    initial begin
        tx_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rstn_i && tx_req_o) begin
                tick();
                tick();
                tx_done_i = 1'b1;
                tick();
                tx_done_i = 1'b0;
            end
        end
    end

    // scoreboard for command bytes
    always @(negedge clk_i) begin
        if (rstn_i && tx_req_o) begin
            if (exp_tx.size() == 0) check("tx_req_extra", {24'd0, tx_byte_o}, 32'hFFFF_FFFF);
            else                    check("tx_byte", {24'd0, tx_byte_o}, {24'd0, exp_tx.pop_front()});
        end
    end

    initial begin
        int cyc;
        rstn_i = 1'b0; start_i = 1'b0; tx_err_i = 1'b0; rx_byte_i = 8'h00;
        rx_valid_i = 1'b0; rx_err_i = 1'b0; pkt_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_tx", {23'd0, tx_req_o, tx_byte_o}, 32'd0);
        check("rst_pkt", {9'd0, pkt_valid_o, pkt_lost_o, dx_o, dy_o, btn_o}, 32'd0);
        check("rst_status", {30'd0, init_done_o, init_fail_o}, 32'd0);
        rstn_i = 1'b1;
        tick();

        // nominal init
        pulse_start();
        wait_tx();
        finish_init();
        check("nom_done", {31'd0, init_done_o}, 32'd1);
        check("nom_fail", {31'd0, init_fail_o}, 32'd0);
        check("nom_tx_count", exp_tx.size(), 32'd0);

        // packet decode
        exp_q.push_back({9'h105, 9'h0FB, 3'b001});
        send_rx(8'h19); send_rx(8'h05); send_rx(8'hFB);
        check("dec_valid", {31'd0, pkt_valid_o}, 32'd1);
        check_pkt("dec_data");
        ack_pkt();
        check("dec_ack_clear", {31'd0, pkt_valid_o}, 32'd0);

        exp_q.push_back({9'h000, 9'h020, 3'b001});
        send_rx(8'h49); send_rx(8'h10); send_rx(8'h20);
        check("ovf_valid", {31'd0, pkt_valid_o}, 32'd1);
        check_pkt("ovf_data");
        ack_pkt();

        // resync and gap drop
        send_rx(8'h00); send_rx(8'h08); send_rx(8'h01);
        repeat (GAP + 5) tick();
        check("gap_no_pkt", {31'd0, pkt_valid_o}, 32'd0);
        exp_q.push_back({9'd2, 9'd3, 3'b000});
        send_rx(8'h08); send_rx(8'h02); send_rx(8'h03);
        check("gap_valid", {31'd0, pkt_valid_o}, 32'd1);
        check_pkt("gap_data");

        // completion and ack in the same cycle
        exp_q.push_back({9'd5, 9'd6, 3'b000});
        send_rx(8'h08); send_rx(8'h05);
        pkt_ack_i = 1'b1;
        send_rx(8'h06);
        pkt_ack_i = 1'b0;
        check("same_valid", {31'd0, pkt_valid_o}, 32'd1);
        check("same_lost", {31'd0, pkt_lost_o}, 32'd0);
        check_pkt("same_data");
        ack_pkt();

        // back-pressure
        send_rx(8'h09); send_rx(8'h01); send_rx(8'h02);
        exp_q.push_back({9'h103, 9'h004, 3'b000});
        send_rx(8'h18); send_rx(8'h03); send_rx(8'h04);
        check("bp_valid", {31'd0, pkt_valid_o}, 32'd1);
        check("bp_lost", {31'd0, pkt_lost_o}, 32'd1);
        check_pkt("bp_data");
        ack_pkt();
        check("bp_ack_clear", {31'd0, pkt_valid_o}, 32'd0);
        check("bp_lost_sticky", {31'd0, pkt_lost_o}, 32'd1);

        // start clears loss; resend and retry accounting
        pulse_start();
        check("start_lost_clr", {31'd0, pkt_lost_o}, 32'd0);
        check("start_left_stream", {31'd0, init_done_o}, 32'd0);
        wait_tx();
        exp_tx.push_back(8'hFF);
        send_rx(8'hFE);
        wait_tx();
        check("resend_retries", {30'd0, dut.retry_q}, 32'd0);
        exp_tx.push_back(8'hFF);
        send_rx(8'h55);
        wait_tx();
        check("bad_byte_retries", {30'd0, dut.retry_q}, 32'd1);
        finish_init();
        check("retry_then_done", {31'd0, init_done_o}, 32'd1);

        // timeout exhaustion
        pulse_start();
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hFF);
        cyc = 1;
        while (!init_fail_o && cyc < 500) begin
            tick();
            cyc++;
        end
        check("tmo_fail", {31'd0, init_fail_o}, 32'd1);
        check("tmo_latency_in_range", {31'd0, (cyc >= 300 && cyc <= 320)}, 32'd1);
        check("tmo_tx_count", exp_tx.size(), 32'd0);

        // restart from FAIL
        pulse_start();
        check("restart_fail_clr", {31'd0, init_fail_o}, 32'd0);
        wait_tx();
        check("restart_tx_count", exp_tx.size(), 32'd0);
        finish_init();
        check("restart_done", {31'd0, init_done_o}, 32'd1);

        // async reset mid-packet
        send_rx(8'h19); send_rx(8'h05);
        rstn_i = 1'b0;
        #2;
        check("areset_outputs",
              {3'd0, tx_req_o, tx_byte_o, pkt_valid_o, pkt_lost_o, dx_o, dy_o, btn_o}, 32'd0);
        check("areset_status", {30'd0, init_done_o, init_fail_o}, 32'd0);
        #10;
        rstn_i = 1'b1;
        tick();

        check("sb_pkt_empty", exp_q.size(), 32'd0);
        check("sb_tx_empty", exp_tx.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
